// File: rtl/eggtimer_pkg.sv
// eggtimer_pkg: shared FSM states, BCD widths/limits and cursor indices for the egg-timer front end
package eggtimer_pkg;
    typedef enum logic [2:0] {EDIT, LOAD, RUN, PAUSE, ALARM} state_t;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC10_MAX = 4'd5;
    localparam logic [1:0] CUR_S1  = 2'd0;
    localparam logic [1:0] CUR_S10 = 2'd1;
    localparam logic [1:0] CUR_M1  = 2'd2;
    localparam logic [1:0] CUR_M10 = 2'd3;
endpackage

// File: rtl/bcd_wrap_inc.sv
// bcd_wrap_inc: combinational BCD digit increment that wraps to zero after max
//   digit      in  4  current digit value
//   max        in  4  largest legal value of this digit
//   digit_next out 4  digit+1, or 0 when digit==max
module bcd_wrap_inc
    import eggtimer_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic [BCD_W-1:0] max,
    output logic [BCD_W-1:0] digit_next
);
    assign digit_next = (digit == max) ? '0 : digit + 1'b1;
endmodule

// File: rtl/eggtimer_preset_ctrl.sv
// eggtimer_preset_ctrl: MM:SS egg-timer front end - preset editing, chain load/enable, alarm
//   clk, reset  in   system clock, synchronous active-high reset
//   tick_1hz    in   one-cycle strobe per second
//   btn_sel/inc/start/clear in  one-cycle debounced button strobes
//   chain_zero  in   all digits of the downcounter chain are zero
//   preset      out  {min10,min1,sec10,sec1} BCD preset for the chain
//   load        out  one-cycle chain load strobe
//   count_en    out  sec1 count enable (combinational)
//   cursor      out  edited digit, 0=sec1 .. 3=min10
//   running     out  high in RUN
//   alarm       out  high in ALARM
module eggtimer_preset_ctrl
    import eggtimer_pkg::*;
#(
    parameter int DEFAULT_MIN = 3,
    parameter int ALARM_SECS  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        chain_zero,
    output logic [15:0] preset,
    output logic        load,
    output logic        count_en,
    output logic [1:0]  cursor,
    output logic        running,
    output logic        alarm
);
    localparam logic [15:0] PRESET_RST = {4'd0, 4'(DEFAULT_MIN), 8'h00};
    localparam logic [3:0]  ALARM_LAST = 4'(ALARM_SECS - 1);

    state_t           state, next_state;
    logic             settled;
    logic [3:0]       alarm_cnt;
    logic [BCD_W-1:0] cur_digit, cur_max, inc_digit;
    logic             zero_hit, edit_act;

    assign cur_digit = preset[{cursor, 2'b00} +: BCD_W];
    assign cur_max   = (cursor == CUR_S10) ? SEC10_MAX : DIGIT_MAX;

    bcd_wrap_inc u_inc (
        .digit      (cur_digit),
        .max        (cur_max),
        .digit_next (inc_digit)
    );

    // settled is low only in the first RUN cycle after LOAD, while the chain absorbs the load
    assign zero_hit = (state == RUN) && settled && chain_zero;
    // start (even an ignored one) outranks sel/inc, so editing only happens without it
    assign edit_act = (state == EDIT) && !btn_clear && !btn_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EDIT;
            load      <= 1'b0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            settled   <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state     <= next_state;
            load      <= next_state == LOAD;
            running   <= next_state == RUN;
            alarm     <= next_state == ALARM;
            settled   <= state != LOAD;
            alarm_cnt <= (next_state == EDIT) ? '0 : (state == ALARM && tick_1hz) ? alarm_cnt + 1'b1 : alarm_cnt;
        end
    end

    always_comb begin
        next_state = state;
        if (btn_clear)
            next_state = EDIT;
        else
            case (state)
                EDIT:    if (btn_start && preset != '0) next_state = LOAD;
                LOAD:    next_state = RUN;
                RUN:     next_state = zero_hit ? ALARM : btn_start ? PAUSE : RUN;
                PAUSE:   if (btn_start) next_state = RUN;
                ALARM:   if (btn_start || btn_sel || btn_inc || (tick_1hz && alarm_cnt == ALARM_LAST)) next_state = EDIT;
                default: next_state = EDIT;
            endcase
    end

    always_comb begin
        count_en = tick_1hz && state == RUN && !zero_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset <= PRESET_RST;
            cursor <= CUR_S1;
        end else if (edit_act && btn_sel) begin
            cursor <= cursor + 1'b1;
        end else if (edit_act && btn_inc) begin
            preset[{cursor, 2'b00} +: BCD_W] <= inc_digit;
        end
    end
endmodule

// File: tb/tb_eggtimer_preset_ctrl.sv
// tb_eggtimer_preset_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_eggtimer_preset_ctrl;
    localparam int DEF_MIN = 3;
    localparam int A_SECS  = 5;
    localparam int M_EDIT = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_ALARM = 4;

    logic clk = 0, reset = 0, tick_1hz = 0, btn_sel = 0, btn_inc = 0, btn_start = 0, btn_clear = 0, chain_zero = 0;
    logic [15:0] preset;
    logic [1:0]  cursor;
    logic        load, count_en, running, alarm;
    int checks = 0, fails = 0;

    int m_mode, m_cur, m_ticks;
    int m_dig[4];
    bit m_fresh;

    eggtimer_preset_ctrl #(.DEFAULT_MIN(DEF_MIN), .ALARM_SECS(A_SECS)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_sel(btn_sel), .btn_inc(btn_inc),
        .btn_start(btn_start), .btn_clear(btn_clear), .chain_zero(chain_zero), .preset(preset),
        .load(load), .count_en(count_en), .cursor(cursor), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] snap();
        return {preset, cursor, load, running, alarm};
    endfunction

    task automatic cyc(input logic s, input logic i, input logic st, input logic c, input logic t);
        btn_sel = s; btn_inc = i; btn_start = st; btn_clear = c; tick_1hz = t;
        @(posedge clk); #1;
        btn_sel = 0; btn_inc = 0; btn_start = 0; btn_clear = 0; tick_1hz = 0;
    endtask

    task automatic do_reset();
        reset = 1; chain_zero = 0;
        cyc(0, 0, 0, 0, 0);
        reset = 0;
    endtask

    task automatic enter_alarm();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chain_zero = 1;
        cyc(0, 0, 0, 0, 0);
        chain_zero = 0;
    endtask

    task automatic model_reset();
        m_mode = M_EDIT; m_cur = 0; m_ticks = 0; m_fresh = 0;
        m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = DEF_MIN; m_dig[3] = 0;
    endtask

    task automatic model_step(input logic s, input logic i, input logic st, input logic c, input logic t, input logic z);
        int nm;
        nm = m_mode;
        if (c) nm = M_EDIT;
        else if (m_mode == M_EDIT) begin
            if (st) begin
                if (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] != 0) nm = M_LOAD;
            end else if (s) m_cur = (m_cur + 1) % 4;
            else if (i) m_dig[m_cur] = (m_dig[m_cur] == (m_cur == 1 ? 5 : 9)) ? 0 : m_dig[m_cur] + 1;
        end else if (m_mode == M_LOAD) nm = M_RUN;
        else if (m_mode == M_RUN) begin
            if (z && !m_fresh) nm = M_ALARM;
            else if (st) nm = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (st) nm = M_RUN;
        end else begin
            if (st || s || i) nm = M_EDIT;
            else if (t) begin
                m_ticks++;
                if (m_ticks == A_SECS) nm = M_EDIT;
            end
        end
        m_fresh = (m_mode == M_LOAD);
        if (nm == M_EDIT) m_ticks = 0;
        m_mode = nm;
    endtask

    task automatic test_reset();
        reset = 1;
        cyc(0, 1, 1, 0, 1);
        reset = 0;
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b000}) begin fails++; $display("FAIL reset_state: got %h want %h", snap(), {16'h0300, 2'd0, 3'b000}); end
        tick_1hz = 1; #1;
        checks++; if (count_en !== 1'b0) begin fails++; $display("FAIL reset_count_en: got %b want 0", count_en); end
        tick_1hz = 0;
    endtask

    task automatic test_start_load();
        do_reset();
        cyc(0, 0, 1, 0, 0);
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b100}) begin fails++; $display("FAIL load_pulse: got %h want %h", snap(), {16'h0300, 2'd0, 3'b100}); end
        tick_1hz = 1; #1;
        checks++; if (count_en !== 1'b0) begin fails++; $display("FAIL load_count_en: got %b want 0", count_en); end
        tick_1hz = 0;
        cyc(0, 0, 0, 0, 0);
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b010}) begin fails++; $display("FAIL run_after_load: got %h want %h", snap(), {16'h0300, 2'd0, 3'b010}); end
        tick_1hz = 1; #1;
        checks++; if (count_en !== 1'b1) begin fails++; $display("FAIL run_count_en: got %b want 1", count_en); end
        tick_1hz = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        checks++; if ({preset, cursor} !== {16'h0350, 2'd1}) begin fails++; $display("FAIL sec10_to_5: got %h want %h", {preset, cursor}, {16'h0350, 2'd1}); end
        cyc(0, 1, 0, 0, 0);
        checks++; if ({preset, cursor} !== {16'h0300, 2'd1}) begin fails++; $display("FAIL sec10_wrap: got %h want %h", {preset, cursor}, {16'h0300, 2'd1}); end
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (9) cyc(0, 1, 0, 0, 0);
        checks++; if ({preset, cursor} !== {16'h0309, 2'd0}) begin fails++; $display("FAIL sec1_to_9: got %h want %h", {preset, cursor}, {16'h0309, 2'd0}); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (preset !== 16'h0300) begin fails++; $display("FAIL sec1_wrap: got %h want 0300", preset); end
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (9) cyc(0, 1, 0, 0, 0);
        checks++; if ({preset, cursor} !== {16'h9300, 2'd3}) begin fails++; $display("FAIL min10_to_9: got %h want %h", {preset, cursor}, {16'h9300, 2'd3}); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (preset !== 16'h0300) begin fails++; $display("FAIL min10_wrap: got %h want 0300", preset); end
    endtask

    task automatic test_zero_preset();
        do_reset();
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (7) cyc(0, 1, 0, 0, 0);
        checks++; if ({preset, cursor} !== {16'h0000, 2'd2}) begin fails++; $display("FAIL min1_to_zero: got %h want %h", {preset, cursor}, {16'h0000, 2'd2}); end
        cyc(0, 0, 1, 0, 0);
        checks++; if (snap() !== {16'h0000, 2'd2, 3'b000}) begin fails++; $display("FAIL start_zero_ignored: got %h want %h", snap(), {16'h0000, 2'd2, 3'b000}); end
        cyc(0, 0, 0, 0, 0);
        checks++; if (snap() !== {16'h0000, 2'd2, 3'b000}) begin fails++; $display("FAIL still_edit: got %h want %h", snap(), {16'h0000, 2'd2, 3'b000}); end
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
        checks++; if (cursor !== 2'd2) begin fails++; $display("FAIL cursor_wrap: got %0d want 2", cursor); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (preset !== 16'h0100) begin fails++; $display("FAIL edit_after_ignore: got %h want 0100", preset); end
    endtask

    task automatic test_pause();
        do_reset();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        tick_1hz = 1; btn_start = 1; #1;
        checks++; if (count_en !== 1'b1) begin fails++; $display("FAIL run_tick: got %b want 1", count_en); end
        cyc(0, 0, 1, 0, 1);
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b000}) begin fails++; $display("FAIL pause_state: got %h want %h", snap(), {16'h0300, 2'd0, 3'b000}); end
        repeat (3) begin
            tick_1hz = 1; #1;
            checks++; if (count_en !== 1'b0) begin fails++; $display("FAIL pause_tick: got %b want 0", count_en); end
            cyc(0, 0, 0, 0, 1);
        end
        cyc(0, 0, 1, 0, 0);
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b010}) begin fails++; $display("FAIL resume_no_load: got %h want %h", snap(), {16'h0300, 2'd0, 3'b010}); end
        tick_1hz = 1; #1;
        checks++; if (count_en !== 1'b1) begin fails++; $display("FAIL resume_tick: got %b want 1", count_en); end
        tick_1hz = 0;
    endtask

    task automatic test_alarm();
        do_reset();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chain_zero = 1; tick_1hz = 1; #1;
        checks++; if (count_en !== 1'b1) begin fails++; $display("FAIL zero_unsettled_count_en: got %b want 1", count_en); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b010}) begin fails++; $display("FAIL zero_unsettled_ignored: got %h want %h", snap(), {16'h0300, 2'd0, 3'b010}); end
        tick_1hz = 1; btn_start = 1; #1;
        checks++; if (count_en !== 1'b0) begin fails++; $display("FAIL zero_forces_count_en: got %b want 0", count_en); end
        cyc(0, 0, 1, 0, 1);
        chain_zero = 0;
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b001}) begin fails++; $display("FAIL enter_alarm: got %h want %h", snap(), {16'h0300, 2'd0, 3'b001}); end
        for (int k = 1; k <= A_SECS; k++) begin
            cyc(0, 0, 0, 0, 1);
            checks++; if (alarm !== (k < A_SECS)) begin fails++; $display("FAIL alarm_hold tick %0d: got %b want %b", k, alarm, k < A_SECS); end
            cyc(0, 0, 0, 0, 0);
        end
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b000}) begin fails++; $display("FAIL alarm_timeout: got %h want %h", snap(), {16'h0300, 2'd0, 3'b000}); end
    endtask

    task automatic test_alarm_exit();
        do_reset();
        enter_alarm();
        cyc(1, 0, 0, 0, 0);
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b000}) begin fails++; $display("FAIL alarm_button_exit: got %h want %h", snap(), {16'h0300, 2'd0, 3'b000}); end
        enter_alarm();
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_clear: got %b want 0", alarm); end
        enter_alarm();
        repeat (A_SECS - 1) cyc(0, 0, 0, 0, 1);
        checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL alarm_cnt_cleared: got %b want 1", alarm); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_cnt_expire: got %b want 0", alarm); end
    endtask

    task automatic test_clear_reset();
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        checks++; if (snap() !== {16'h0310, 2'd1, 3'b000}) begin fails++; $display("FAIL clear_beats_start: got %h want %h", snap(), {16'h0310, 2'd1, 3'b000}); end
        cyc(1, 0, 0, 0, 0);
        checks++; if (cursor !== 2'd2) begin fails++; $display("FAIL edit_after_clear: got %0d want 2", cursor); end
        cyc(0, 0, 1, 0, 0);
        checks++; if (snap() !== {16'h0310, 2'd2, 3'b100}) begin fails++; $display("FAIL load_again: got %h want %h", snap(), {16'h0310, 2'd2, 3'b100}); end
        reset = 1;
        cyc(0, 0, 0, 0, 0);
        reset = 0;
        checks++; if (snap() !== {16'h0300, 2'd0, 3'b000}) begin fails++; $display("FAIL reset_in_load: got %h want %h", snap(), {16'h0300, 2'd0, 3'b000}); end
        cyc(0, 0, 0, 0, 0);
        checks++; if ({load, running} !== 2'b00) begin fails++; $display("FAIL no_late_load: got %b want 00", {load, running}); end
    endtask

    task automatic test_random();
        logic r, s, i, st, c, t, z, exp_ce;
        logic [20:0] exp;
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 249) == 0;
            s = $urandom_range(0, 5) == 0;
            i = $urandom_range(0, 2) == 0;
            st = $urandom_range(0, 7) == 0;
            c = $urandom_range(0, 39) == 0;
            t = $urandom_range(0, 2) == 0;
            z = $urandom_range(0, 5) == 0;
            reset = r; btn_sel = s; btn_inc = i; btn_start = st; btn_clear = c; tick_1hz = t; chain_zero = z;
            exp_ce = t && m_mode == M_RUN && !(z && !m_fresh);
            #1;
            checks++; if (count_en !== exp_ce) begin fails++; $display("FAIL rand_count_en cycle %0d: got %b want %b", n, count_en, exp_ce); end
            if (r) model_reset();
            else model_step(s, i, st, c, t, z);
            @(posedge clk); #1;
            exp = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]), 2'(m_cur),
                   m_mode == M_LOAD, m_mode == M_RUN, m_mode == M_ALARM};
            checks++; if (snap() !== exp) begin fails++; $display("FAIL rand_state cycle %0d: got %h want %h", n, snap(), exp); end
        end
        reset = 0; btn_sel = 0; btn_inc = 0; btn_start = 0; btn_clear = 0; tick_1hz = 0; chain_zero = 0;
    endtask

    initial begin
        test_reset();
        test_start_load();
        test_wrap();
        test_zero_preset();
        test_pause();
        test_alarm();
        test_alarm_exit();
        test_clear_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
